// File: rtl/adc_fill_ctrl_pkg.sv
// Shared types and widths for the ADC burst fill controller.
package adc_fill_ctrl_pkg;

  localparam int CNT_W = 21;
  localparam int TS_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

endpackage

// File: rtl/adc_fill_ctrl_if.sv
// Sample input stream and packed-burst output bus of the fill controller.
// Handshake: a burst transfers on any cycle with burst_valid && burst_ready;
// while burst_valid=1 and burst_ready=0, burst_data and burst_last hold stable.
interface adc_fill_ctrl_if #(
  parameter int SAMPLE_W  = 12,
  parameter int BURST_LEN = 8
);
  logic [SAMPLE_W-1:0]           adc_data;
  logic                          adc_valid;
  logic [SAMPLE_W*BURST_LEN-1:0] burst_data;
  logic                          burst_valid;
  logic                          burst_ready;
  logic                          burst_last;

  modport master (
    output adc_data, adc_valid, burst_ready,
    input  burst_data, burst_valid, burst_last
  );

  modport slave (
    input  adc_data, adc_valid, burst_ready,
    output burst_data, burst_valid, burst_last
  );
endinterface

// File: rtl/adc_burst_packer.sv
// Packs BURST_LEN samples into one word (first sample in the LSBs) and holds
// it in a single output register; a burst completing while that register is full drops.
module adc_burst_packer #(
  parameter int SAMPLE_W  = 12,
  parameter int BURST_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          sample_valid,
  input  logic [SAMPLE_W-1:0]           sample_data,
  input  logic                          last_tag,
  input  logic                          out_ready,
  output logic [SAMPLE_W*BURST_LEN-1:0] out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          complete,
  output logic                          dropped
);
  localparam int IDX_W = $clog2(BURST_LEN);

  logic [IDX_W-1:0]              idx;
  logic [SAMPLE_W*BURST_LEN-1:0] pack_q;
  logic [SAMPLE_W*BURST_LEN-1:0] pack_next;
  logic                          load_ok;

  always_comb begin
    pack_next = pack_q;
    pack_next[int'(idx)*SAMPLE_W +: SAMPLE_W] = sample_data;
  end

  assign complete = sample_valid && (idx == IDX_W'(BURST_LEN - 1));
  // The register frees up in the same cycle it is accepted, so back-to-back bursts never drop.
  assign load_ok  = !out_valid || out_ready;
  assign dropped  = complete && !load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      pack_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (clear) begin
        idx <= '0;
      end else if (sample_valid) begin
        pack_q <= pack_next;
        idx    <= complete ? '0 : idx + 1'b1;
      end
      if (complete && load_ok) begin
        out_data  <= pack_next;
        out_valid <= 1'b1;
        out_last  <= last_tag;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/adc_fill_ctrl.sv
// ADC fill controller: on a trigger, collects num_fill_bursts packed bursts.
// Optional ADC_FILL_TIMESTAMP_EN adds a free-running counter latched on trigger.
module adc_fill_ctrl
  import adc_fill_ctrl_pkg::*;
#(
  parameter int SAMPLE_W  = 12,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [CNT_W-1:0]  num_fill_bursts,
  adc_fill_ctrl_if.slave    bus,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              overflow,
`ifdef ADC_FILL_TIMESTAMP_EN
  output logic [TS_W-1:0]   fill_timestamp,
`endif
  output fill_state_e       dbg_state
);
  fill_state_e                   state;
  logic [CNT_W-1:0]              cnt;
  logic                          last_dropped;
  logic                          start;
  logic                          sample_en;
  logic                          last_tag;
  logic                          complete;
  logic                          dropped;
  logic [SAMPLE_W*BURST_LEN-1:0] pk_data;
  logic                          pk_valid;
  logic                          pk_last;

  assign start     = (state == ST_IDLE) && trig && (num_fill_bursts != '0);
  assign sample_en = (state == ST_FILL) && bus.adc_valid;
  assign last_tag  = (cnt == CNT_W'(1));
  assign dbg_state = state;

  adc_burst_packer #(
    .SAMPLE_W  (SAMPLE_W),
    .BURST_LEN (BURST_LEN)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start),
    .sample_valid (sample_en),
    .sample_data  (bus.adc_data),
    .last_tag     (last_tag),
    .out_ready    (bus.burst_ready),
    .out_data     (pk_data),
    .out_valid    (pk_valid),
    .out_last     (pk_last),
    .complete     (complete),
    .dropped      (dropped)
  );

  assign bus.burst_data  = pk_data;
  assign bus.burst_valid = pk_valid;
  assign bus.burst_last  = pk_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      last_dropped <= 1'b0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            if (num_fill_bursts != '0) begin
              state        <= ST_FILL;
              cnt          <= num_fill_bursts;
              overflow     <= 1'b0;
              last_dropped <= 1'b0;
              fill_busy    <= 1'b1;
            end else begin
              fill_done <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (complete) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (dropped) overflow <= 1'b1;
            if (last_tag) begin
              state        <= ST_DRAIN;
              last_dropped <= dropped;
            end
          end
        end
        ST_DRAIN: begin
          // A dropped final burst never reaches the output, so leave without waiting for it.
          if (last_dropped || (pk_valid && bus.burst_ready && pk_last)) begin
            state     <= ST_IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADC_FILL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt         <= '0;
      fill_timestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if ((state == ST_IDLE) && trig) fill_timestamp <= ts_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_adc_fill_ctrl.sv
// Bench for adc_fill_ctrl: directed fills plus randomized fills against a
// burst-level reference model (partial-sample queue, one-entry hold queue).
module tb_adc_fill_ctrl;
  import adc_fill_ctrl_pkg::*;

  localparam int SW = 12;
  localparam int BL = 8;
  localparam int BW = SW * BL;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trig = 1'b0;
  logic [CNT_W-1:0] num_fill_bursts = '0;
  logic             fill_busy;
  logic             fill_done;
  logic             overflow;
  fill_state_e      dbg_state;
`ifdef ADC_FILL_TIMESTAMP_EN
  logic [TS_W-1:0]  fill_timestamp;
`endif

  adc_fill_ctrl_if #(.SAMPLE_W(SW), .BURST_LEN(BL)) bus_if ();

  adc_fill_ctrl #(.SAMPLE_W(SW), .BURST_LEN(BL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trig            (trig),
    .num_fill_bursts (num_fill_bursts),
    .bus             (bus_if),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .overflow        (overflow),
`ifdef ADC_FILL_TIMESTAMP_EN
    .fill_timestamp  (fill_timestamp),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int last_cnt = 0;

  // ---------------- reference model ----------------
  bit            m_active, m_collect, m_drain_drop, m_ovf, m_done;
  int            m_left;
  logic [SW-1:0] part_q[$];
  logic [BW-1:0] hold_q[$];
  bit            hold_last_q[$];

  task automatic model_reset();
    m_active = 0; m_collect = 0; m_drain_drop = 0; m_ovf = 0; m_done = 0;
    m_left = 0;
    part_q.delete(); hold_q.delete(); hold_last_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit            had, xfer, xfer_last, done_n, is_last;
    logic [BW-1:0] pk;
    done_n = 0;
    had = hold_q.size() != 0;
    xfer = had && bus_if.burst_ready;
    xfer_last = xfer && hold_last_q[0];
    if (xfer) begin
      void'(hold_q.pop_front());
      void'(hold_last_q.pop_front());
    end
    if (!m_active) begin
      if (trig) begin
        if (num_fill_bursts != 0) begin
          m_active = 1; m_collect = 1; m_left = int'(num_fill_bursts);
          m_ovf = 0; m_drain_drop = 0; part_q.delete();
        end else begin
          done_n = 1;
        end
      end
    end else if (!m_collect) begin
      if (m_drain_drop || xfer_last) begin
        m_active = 0;
        done_n = 1;
      end
    end else if (bus_if.adc_valid) begin
      part_q.push_back(bus_if.adc_data);
      if (part_q.size() == BL) begin
        pk = '0;
        foreach (part_q[i]) pk[i*SW +: SW] = part_q[i];
        is_last = (m_left == 1);
        if (m_left > 0) m_left--;
        if (hold_q.size() == 0) begin
          hold_q.push_back(pk);
          hold_last_q.push_back(is_last);
        end else begin
          m_ovf = 1;
          if (is_last) m_drain_drop = 1;
        end
        if (is_last) m_collect = 0;
        part_q.delete();
      end
    end
    m_done = done_n;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    fill_state_e exp_st;
    exp_st = !m_active ? ST_IDLE : (m_collect ? ST_FILL : ST_DRAIN);
    check("fill_busy", fill_busy, m_active);
    check("fill_done", fill_done, m_done);
    check("overflow", overflow, m_ovf);
    check("state", dbg_state, exp_st);
    check("burst_valid", bus_if.burst_valid, hold_q.size() != 0);
    check("burst_last", bus_if.burst_last, (hold_q.size() != 0) ? hold_last_q[0] : 1'b0);
    if (hold_q.size() != 0) check("burst_data", bus_if.burst_data, hold_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (bus_if.burst_valid && bus_if.burst_ready) begin
      xfer_cnt++;
      if (bus_if.burst_last) last_cnt++;
    end
    model_edge();
    @(posedge clk);
    #1;
    trig = 1'b0;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit r);
    bus_if.adc_valid   = v;
    bus_if.adc_data    = SW'($urandom);
    bus_if.burst_ready = r;
    step();
  endtask

  task automatic start_fill(input int n, input bit r);
    xfer_cnt = 0;
    last_cnt = 0;
    num_fill_bursts = CNT_W'(n);
    trig = 1'b1;
    drive(1'b0, r);
  endtask

  task automatic wait_idle(input int vpct, input int rpct, input bit rtrig);
    int n;
    n = 0;
    while (m_active && n < 400) begin
      if (rtrig && $urandom_range(0, 15) == 0) begin
        trig = 1'b1;
        num_fill_bursts = CNT_W'($urandom_range(1, 6));
      end
      drive($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct);
      n++;
    end
    check("fill_end", fill_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.adc_valid   = 1'b0;
    bus_if.adc_data    = '0;
    bus_if.burst_ready = 1'b0;
    model_reset();

    // reset state
    #1;
    check("rst_burst_valid", bus_if.burst_valid, 1'b0);
    check("rst_burst_last", bus_if.burst_last, 1'b0);
    check("rst_burst_data", bus_if.burst_data, '0);
    check("rst_fill_busy", fill_busy, 1'b0);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b1);

    // three bursts, continuous samples, always ready
    start_fill(3, 1'b1);
    repeat (24) drive(1'b1, 1'b1);
    wait_idle(0, 100, 1'b0);
    drive(1'b0, 1'b1);
    check("basic_xfers", xfer_cnt, 3);
    check("basic_lasts", last_cnt, 1);
    check("basic_overflow", overflow, 1'b0);

    // zero-burst trigger
    start_fill(0, 1'b1);
    check("zero_busy", fill_busy, 1'b0);
    repeat (3) drive(1'b0, 1'b1);
    check("zero_xfers", xfer_cnt, 0);

    // stalled downstream: bursts 2 and 3 drop
    start_fill(4, 1'b0);
    repeat (28) drive(1'b1, 1'b0);
    check("stall_overflow", overflow, 1'b1);
    wait_idle(100, 100, 1'b0);
    drive(1'b0, 1'b1);
    check("stall_xfers", xfer_cnt, 2);
    check("stall_lasts", last_cnt, 1);
    check("stall_overflow_sticky", overflow, 1'b1);

    // back-to-back: ready only in the cycle the second burst completes
    start_fill(2, 1'b0);
    repeat (15) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("b2b_valid", bus_if.burst_valid, 1'b1);
    check("b2b_overflow", overflow, 1'b0);
    wait_idle(0, 100, 1'b0);
    drive(1'b0, 1'b1);
    check("b2b_xfers", xfer_cnt, 2);

    // second trigger mid-fill is ignored
    start_fill(3, 1'b1);
    repeat (10) drive(1'b1, 1'b1);
    num_fill_bursts = CNT_W'(7);
    trig = 1'b1;
    drive(1'b1, 1'b1);
    wait_idle(100, 100, 1'b0);
    drive(1'b0, 1'b1);
    check("retrig_xfers", xfer_cnt, 3);

    // asynchronous reset mid-fill with a held burst
    start_fill(2, 1'b0);
    repeat (12) drive(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_burst_valid", bus_if.burst_valid, 1'b0);
    check("arst_burst_last", bus_if.burst_last, 1'b0);
    check("arst_burst_data", bus_if.burst_data, '0);
    check("arst_fill_busy", fill_busy, 1'b0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_state", dbg_state, ST_IDLE);
    model_reset();
    #1;
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1);

    // randomized fills with random samples, backpressure and stray triggers
    for (int f = 0; f < 12; f++) begin
      start_fill($urandom_range(0, 4), $urandom_range(0, 1));
      wait_idle(75, 60, 1'b1);
      repeat (2) drive(1'b0, 1'b1);
    end

`ifdef ADC_FILL_TIMESTAMP_EN
    // timestamp latched when the free-running counter reads 100
    rst_n = 1'b0;
    model_reset();
    #2;
    check("ts_reset", fill_timestamp, '0);
    rst_n = 1'b1;
    repeat (100) drive(1'b0, 1'b1);
    num_fill_bursts = '0;
    trig = 1'b1;
    drive(1'b0, 1'b1);
    check("ts_latch", fill_timestamp, 100);
    repeat (5) drive(1'b0, 1'b1);
    check("ts_hold", fill_timestamp, 100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
